// File: rtl/i2c_reg_arbiter.sv
// 256x8 register file shared by an I2C slave port and a host port.
// Optional I2C write protection of the upper address range: I2C_REG_WPROT_EN.
module i2c_reg_arbiter #(
    parameter logic [7:0] REG_RST_VAL = 8'h00,
    parameter logic [7:0] WPROT_BASE  = 8'hF0
) (
    input  logic       i_sclk,
    input  logic       i_rst_n,
    input  logic       i_i2c_wr_de,
    input  logic [7:0] i_i2c_wr_addr,
    input  logic [7:0] i_i2c_wr_data,
    input  logic       i_i2c_wr_done,
    input  logic [8:0] i_i2c_wr_length,
    input  logic       i_i2c_rd_de,
    input  logic [7:0] i_i2c_rd_addr,
    output logic [7:0] o_i2c_rd_data,
    input  logic       i_host_req,
    input  logic       i_host_wr,
    input  logic [7:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic       o_host_ack,
    output logic [7:0] o_host_rdata,
    output logic       o_upd_irq,
    output logic [8:0] o_upd_len,
    output logic [7:0] o_host_stall_cnt
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I2C_WR,
        ARB_I2C_RD,
        ARB_HOST
    } arb_state_t;

`ifdef I2C_REG_WPROT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    arb_state_t state;
    arb_state_t grant;
    logic [7:0] mem [256];
    logic       wr_ok;
    logic       i2c_busy;
    logic       host_wr_go;

    // A protected I2C write behaves as if no strobe had arrived
    assign wr_ok    = i_i2c_wr_de &&
                      !(PROT_EN && (i_i2c_wr_addr >= WPROT_BASE));
    assign i2c_busy = i_i2c_rd_de || wr_ok;

    always_comb begin
        grant = ARB_IDLE;
        if (i_i2c_rd_de)
            grant = ARB_I2C_RD;
        else if (wr_ok)
            grant = ARB_I2C_WR;
        else if (i_host_req && (state != ARB_HOST))
            grant = ARB_HOST;
    end

    assign host_wr_go = (grant == ARB_HOST) && i_host_wr;

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= REG_RST_VAL;
        end else if (grant == ARB_I2C_WR) begin
            mem[i_i2c_wr_addr] <= i_i2c_wr_data;
        end else if (host_wr_go) begin
            mem[i_host_addr] <= i_host_wdata;
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ARB_IDLE;
            o_i2c_rd_data    <= 8'h00;
            o_host_ack       <= 1'b0;
            o_host_rdata     <= 8'h00;
            o_upd_irq        <= 1'b0;
            o_upd_len        <= 9'd0;
            o_host_stall_cnt <= 8'h00;
        end else begin
            state      <= grant;
            o_host_ack <= (grant == ARB_HOST);
            if (grant == ARB_I2C_RD)
                o_i2c_rd_data <= mem[i_i2c_rd_addr];
            if ((grant == ARB_HOST) && !i_host_wr)
                o_host_rdata <= mem[i_host_addr];
            // The ack cycle is a mandatory gap, not an I2C stall
            if (i_host_req && i2c_busy && (state != ARB_HOST) &&
                (o_host_stall_cnt != 8'hFF))
                o_host_stall_cnt <= o_host_stall_cnt + 8'd1;
            o_upd_irq <= i_i2c_wr_done && (i_i2c_wr_length != 9'd0);
            if (i_i2c_wr_done && (i_i2c_wr_length != 9'd0))
                o_upd_len <= i_i2c_wr_length;
        end
    end

endmodule
